// File: rtl/piano_pkg.sv
// Shared types and constants for the piano key input front end.
package piano_pkg;

  typedef enum logic [1:0] {
    OCT_LOW  = 2'd0,
    OCT_MID  = 2'd1,
    OCT_HIGH = 2'd2
  } oct_state_e;

  localparam int unsigned NOTE_C = 0;
  localparam int unsigned NOTE_D = 1;
  localparam int unsigned NOTE_E = 2;
  localparam int unsigned NOTE_F = 3;
  localparam int unsigned NOTE_G = 4;
  localparam int unsigned NOTE_A = 5;
  localparam int unsigned NOTE_B = 6;

  localparam int unsigned NUM_NOTES = 7;
  localparam int unsigned NUM_BTNS  = 2;

  // Keep only the lowest-indexed set bit (c has the highest priority).
  function automatic logic [NUM_NOTES-1:0] note_priority(input logic [NUM_NOTES-1:0] notes);
    return notes & (~notes + NUM_NOTES'(1));
  endfunction

endpackage

// File: rtl/piano_debounce.sv
// One input channel: 2-flop synchroniser, stability counter, committed level and a
// one-cycle pulse on every 0->1 commit.
module piano_debounce #(
  parameter int unsigned DEBOUNCE_CYCLES = 250000,
  parameter int unsigned CNT_W           = $clog2(DEBOUNCE_CYCLES)
) (
  input  logic clk,
  input  logic rst,
  input  logic raw,
  output logic stable,
  output logic rise
);

  localparam logic [CNT_W-1:0] CntLast = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             meta_q;
  logic             sync_q;
  logic             stable_q;
  logic             rise_q;
  logic [CNT_W-1:0] cnt_q;
  logic             commit;

  // Commit once the synchronised level has disagreed for DEBOUNCE_CYCLES samples.
  assign commit = (sync_q != stable_q) && (cnt_q == CntLast);

  // Synchroniser for the asynchronous raw pin.
  always_ff @(posedge clk) begin
    if (rst) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
    end else begin
      meta_q <= raw;
      sync_q <= meta_q;
    end
  end

  // Stability counter and committed level; any agreement restarts the count.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q    <= '0;
      stable_q <= 1'b0;
      rise_q   <= 1'b0;
    end else begin
      rise_q <= commit & sync_q;
      if (sync_q == stable_q) begin
        cnt_q <= '0;
      end else if (commit) begin
        stable_q <= sync_q;
        cnt_q    <= '0;
      end else begin
        cnt_q <= cnt_q + CNT_W'(1);
      end
    end
  end

  assign stable = stable_q;
  assign rise   = rise_q;

endmodule

// File: rtl/piano_key_input.sv
// Piano key front end: debounces seven note keys and two octave buttons, tracks the
// octave in a LOW/MID/HIGH state machine and registers the note outputs.
// Optional build macro PIANO_SINGLE_NOTE_EN: when defined, only the highest-priority
// held note (c > d > e > f > g > a > b) is presented.
module piano_key_input
  import piano_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = 250000,
  parameter int unsigned CNT_W           = $clog2(DEBOUNCE_CYCLES)
) (
  input  logic clk,
  input  logic rst,
  input  logic key_c,
  input  logic key_d,
  input  logic key_e,
  input  logic key_f,
  input  logic key_g,
  input  logic key_a,
  input  logic key_b,
  input  logic btn_up,
  input  logic btn_down,
  output logic c,
  output logic d,
  output logic e,
  output logic f,
  output logic g,
  output logic a,
  output logic b,
  output logic up,
  output logic down
);

  logic [NUM_NOTES-1:0] raw_notes;
  logic [NUM_NOTES-1:0] note_stable;
  logic [NUM_NOTES-1:0] note_rise;
  logic [NUM_NOTES-1:0] note_sel;
  logic [NUM_NOTES-1:0] notes_q;
  logic [NUM_BTNS-1:0]  raw_btns;
  logic [NUM_BTNS-1:0]  btn_stable;
  logic [NUM_BTNS-1:0]  btn_rise;
  logic                 up_ev;
  logic                 down_ev;
  oct_state_e           state_q;
  oct_state_e           state_d;
  logic                 unused_sigs;

  assign raw_notes[NOTE_C] = key_c;
  assign raw_notes[NOTE_D] = key_d;
  assign raw_notes[NOTE_E] = key_e;
  assign raw_notes[NOTE_F] = key_f;
  assign raw_notes[NOTE_G] = key_g;
  assign raw_notes[NOTE_A] = key_a;
  assign raw_notes[NOTE_B] = key_b;

  // Button 0 steps up, button 1 steps down.
  assign raw_btns = {btn_down, btn_up};

  for (genvar i = 0; i < NUM_NOTES; i++) begin : gen_note_db
    piano_debounce #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
      .CNT_W          (CNT_W)
    ) u_db (
      .clk   (clk),
      .rst   (rst),
      .raw   (raw_notes[i]),
      .stable(note_stable[i]),
      .rise  (note_rise[i])
    );
  end

  for (genvar i = 0; i < NUM_BTNS; i++) begin : gen_btn_db
    piano_debounce #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
      .CNT_W          (CNT_W)
    ) u_db (
      .clk   (clk),
      .rst   (rst),
      .raw   (raw_btns[i]),
      .stable(btn_stable[i]),
      .rise  (btn_rise[i])
    );
  end

  // Buttons only act through their press pulses; note pulses are not needed.
  assign unused_sigs = ^{note_rise, btn_stable};

  assign up_ev   = btn_rise[0];
  assign down_ev = btn_rise[1];

`ifdef PIANO_SINGLE_NOTE_EN
  assign note_sel = note_priority(note_stable);
`else
  assign note_sel = note_stable;
`endif

  // Note output register.
  always_ff @(posedge clk) begin
    if (rst) begin
      notes_q <= '0;
    end else begin
      notes_q <= note_sel;
    end
  end

  // Octave state register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= OCT_MID;
    end else begin
      state_q <= state_d;
    end
  end

  // Octave next state: saturating steps, simultaneous presses cancel.
  always_comb begin
    state_d = state_q;
    unique case ({up_ev, down_ev})
      2'b10: begin
        unique case (state_q)
          OCT_LOW:  state_d = OCT_MID;
          OCT_MID:  state_d = OCT_HIGH;
          OCT_HIGH: state_d = OCT_HIGH;
          default:  state_d = OCT_MID;
        endcase
      end
      2'b01: begin
        unique case (state_q)
          OCT_HIGH: state_d = OCT_MID;
          OCT_MID:  state_d = OCT_LOW;
          OCT_LOW:  state_d = OCT_LOW;
          default:  state_d = OCT_MID;
        endcase
      end
      default: state_d = (state_q == OCT_LOW || state_q == OCT_HIGH) ? state_q : OCT_MID;
    endcase
  end

  assign c    = notes_q[NOTE_C];
  assign d    = notes_q[NOTE_D];
  assign e    = notes_q[NOTE_E];
  assign f    = notes_q[NOTE_F];
  assign g    = notes_q[NOTE_G];
  assign a    = notes_q[NOTE_A];
  assign b    = notes_q[NOTE_B];
  assign up   = (state_q == OCT_HIGH);
  assign down = (state_q == OCT_LOW);

endmodule

// File: tb/tb_piano_key_input.sv
// Scoreboard bench for piano_key_input with DEBOUNCE_CYCLES=4. The reference model
// treats each channel as a sliding window: a committed level flips when the last
// DEBOUNCE_CYCLES synchronised samples all disagree with it.
module tb_piano_key_input;

  localparam int unsigned D   = 4;
  localparam int unsigned NCH = 9;

  logic           clk = 1'b0;
  logic           rst;
  logic [NCH-1:0] raw;  // [6:0] notes c..b, [7] btn_up, [8] btn_down
  logic           c, d, e, f, g, a, b, up, down;

  always #5 clk = ~clk;

  piano_key_input #(
    .DEBOUNCE_CYCLES(D)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .key_c   (raw[0]),
    .key_d   (raw[1]),
    .key_e   (raw[2]),
    .key_f   (raw[3]),
    .key_g   (raw[4]),
    .key_a   (raw[5]),
    .key_b   (raw[6]),
    .btn_up  (raw[7]),
    .btn_down(raw[8]),
    .c       (c),
    .d       (d),
    .e       (e),
    .f       (f),
    .g       (g),
    .a       (a),
    .b       (b),
    .up      (up),
    .down    (down)
  );

  // Reference model state.
  logic [NCH-1:0] m_s1     = '0;
  logic [NCH-1:0] m_s2     = '0;
  logic [NCH-1:0] m_stable = '0;
  logic [1:0]     m_pulse  = '0;
  logic [6:0]     m_notes  = '0;
  int             m_oct    = 0;  // -1 low, 0 mid, +1 high
  logic [NCH-1:0] m_hist[$];     // synchronised samples of the last D edges
  logic [8:0]     exp_q[$];      // {b..c, up, down}

  int vectors    = 0;
  int miscompares = 0;

  function automatic logic [6:0] single_note(input logic [6:0] v);
    logic [6:0] r;
    r = '0;
`ifdef PIANO_SINGLE_NOTE_EN
    for (int i = 0; i < 7; i++) begin
      if (v[i]) begin
        r[i] = 1'b1;
        break;
      end
    end
`else
    r = v;
`endif
    return r;
  endfunction

  // Advance the model by one clock edge with the inputs sampled at that edge.
  task automatic model_step(input logic r, input logic [NCH-1:0] x);
    logic [NCH-1:0] flip;
    logic           up_ev, dn_ev;
    flip = '0;
    if (m_hist.size() == D) begin
      for (int ch = 0; ch < NCH; ch++) begin
        flip[ch] = 1'b1;
        foreach (m_hist[i]) if (m_hist[i][ch] == m_stable[ch]) flip[ch] = 1'b0;
      end
    end
    if (r) begin
      m_s1 = '0; m_s2 = '0; m_stable = '0; m_pulse = '0; m_notes = '0; m_oct = 0;
    end else begin
      m_notes = single_note(m_stable[6:0]);
      up_ev = m_pulse[0];
      dn_ev = m_pulse[1];
      if (up_ev && !dn_ev && m_oct < 1) m_oct++;
      if (dn_ev && !up_ev && m_oct > -1) m_oct--;
      m_pulse  = flip[8:7] & ~m_stable[8:7];
      m_stable = m_stable ^ flip;
      m_s2 = m_s1;
      m_s1 = x;
    end
    m_hist.push_back(m_s2);
    if (m_hist.size() > D) void'(m_hist.pop_front());
    exp_q.push_back({m_notes, (m_oct == 1), (m_oct == -1)});
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      model_step(rst, raw);
      #1;
    end
  endtask

  task automatic press(input int ch, input int hold);
    raw[ch] = 1'b1;
    tick(hold);
    raw[ch] = 1'b0;
    tick(hold);
  endtask

  // Monitor: outputs are valid every cycle; compare on the falling edge.
  always @(negedge clk) begin
    logic [8:0] exp_v, got_v;
    if (exp_q.size() > 0) begin
      exp_v = exp_q.pop_front();
      got_v = {b, a, g, f, e, d, c, up, down};
      vectors++;
      if (got_v !== exp_v) begin
        miscompares++;
        $display("FAIL outputs t=%0t notes(b..c) got %b exp %b up/down got %b exp %b",
                 $time, got_v[8:2], exp_v[8:2], got_v[1:0], exp_v[1:0]);
      end
    end
  end

  initial begin
    int p;
    rst = 1'b1;
    raw = '1;
    // Reset with every key and button held.
    tick(3);
    rst = 1'b0;
    tick(12);
    raw = '0;
    tick(12);
    // Clean press and release of c.
    press(0, 10);
    // Bounce on d: high 3, low 1, then held high.
    raw[1] = 1'b1; tick(3);
    raw[1] = 1'b0; tick(1);
    raw[1] = 1'b1; tick(10);
    raw[1] = 1'b0; tick(10);
    // Octave walk: up, up, down, down, down, up.
    press(7, 8);
    press(7, 8);
    press(8, 8);
    press(8, 8);
    press(8, 8);
    press(7, 8);
    // Simultaneous buttons from MID.
    raw[8:7] = 2'b11; tick(10);
    raw[8:7] = 2'b00; tick(10);
    // Chord e+a, then release e.
    raw[2] = 1'b1; raw[5] = 1'b1; tick(10);
    raw[2] = 1'b0; tick(10);
    raw[5] = 1'b0; tick(10);
    // Reset in the middle of a debounce with the key still held.
    raw[0] = 1'b1; tick(2);
    rst = 1'b1; tick(2);
    rst = 1'b0; tick(10);
    raw[0] = 1'b0; tick(10);
    // Randomised phase with varying activity levels and occasional reset.
    for (int blk = 0; blk < 40; blk++) begin
      case ($urandom_range(0, 3))
        0:       p = 2;
        1:       p = 5;
        2:       p = 12;
        default: p = 30;
      endcase
      for (int cyc = 0; cyc < 80; cyc++) begin
        for (int ch = 0; ch < NCH; ch++) begin
          if ($urandom_range(0, p - 1) == 0) raw[ch] = ~raw[ch];
        end
        rst = ($urandom_range(0, 299) == 0);
        tick(1);
      end
    end
    rst = 1'b0;
    raw = '0;
    tick(12);
    @(negedge clk);
    #1;
    if (exp_q.size() != 0) begin
      miscompares++;
      $display("FAIL drain got %0d pending exp 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/piano_key_input.md
# piano_key_input

Front-end conditioning stage of the electronic piano. It sits between the raw keyboard/button pins and the LED indicator stage.
- Synchronises and debounces the seven note keys and the two octave buttons.
- Tracks the current octave in a three-state machine.
- Presents clean note lines plus `up`/`down` octave levels, which the LED indicator stage consumes directly.

## Interface
- `DEBOUNCE_CYCLES`, default 250000: consecutive stable synchronised samples required to commit a change (5 ms at 50 MHz); legal range ≥ 2.
- `CNT_W`, default `$clog2(DEBOUNCE_CYCLES)`: debounce counter width.

Ports:
- `clk`  in  1  single clock; all logic on rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `key_c`, `key_d`, `key_e`, `key_f`, `key_g`, `key_a`, `key_b`  in  1 each  raw note keys, active-high, asynchronous, bouncing.
- `btn_up`, `btn_down`  in  1 each  raw octave buttons, active-high, asynchronous, bouncing.
- `c`, `d`, `e`, `f`, `g`, `a`, `b`  out  1 each  debounced note levels, registered.
- `up`  out  1  high while octave state is HIGH.
- `down`  out  1  high while octave state is LOW.

## Operation
- **Per channel (9 channels)**
  - 2-flop synchroniser feeds `sync`.
  - Committed level `stable` and counter `cnt` are kept per channel.
  - When `sync != stable`, `cnt` increments.
  - When `sync == stable`, `cnt` clears to 0.
  - When `sync != stable` and `cnt == DEBOUNCE_CYCLES-1`: commit, i.e. `stable <= sync`, `cnt <= 0`.
  - Any bounce back before commit restarts the count from 0.
- **Commit event**: one-cycle internal pulse, generated only on a 0→1 commit of `btn_up` or `btn_down`. 1→0 commits generate nothing.
- **Octave FSM**: states LOW, MID, HIGH; reset state is MID.
  - `up` commit only: LOW→MID, MID→HIGH, HIGH→HIGH (saturates).
  - `down` commit only: HIGH→MID, MID→LOW, LOW→LOW (saturates).
  - Both commits in the same cycle: no state change.
  - Holding a button never repeats a step; release and a new press are required.
- **Outputs**
  - Note outputs are registered from the note `stable` values; see Configuration for masking.
  - `up = (state==HIGH)`, `down = (state==LOW)`; never both high.
- **Reset**, including mid-debounce:
  - Synchroniser flops, all `stable`, all `cnt` and all outputs go to 0.
  - FSM goes to MID.
  - A key held through reset must complete a full debounce interval before its output asserts.

## Timing
- Edge 0 is the first clock edge at which a raw input is sampled at a new level, and the input is held steady from then on.
- `sync` changes at edge 1.
- Commit happens at edge 1+DEBOUNCE_CYCLES.
- Note outputs and the FSM / `up` / `down` all update at edge 2+DEBOUNCE_CYCLES.
- Release takes the same latency as press.
- Throughput: a channel can commit at most once per DEBOUNCE_CYCLES cycles.
- All outputs are 0 in the cycle after reset is released.

## Configuration
- `PIANO_SINGLE_NOTE_EN`
  - **Defined**: at most one note output is high. Fixed priority is c > d > e > f > g > a > b, applied to the `stable` vector before the output register. Releasing the winning key lets the next-highest held key appear at the same output update.
  - **Undefined**: every debounced note passes through unmasked (polyphonic).
  - Octave logic is identical in both builds.

## Structure
- Package `piano_pkg`:
  - octave state enum (`OCT_LOW`, `OCT_MID`, `OCT_HIGH`; 2 bits);
  - note index constants `NOTE_C..NOTE_B` (0..6);
  - `NUM_NOTES=7`, `NUM_BTNS=2`.
- Sub-module `piano_debounce`: one channel, containing synchroniser, counter, `stable` and a rising-commit pulse output. It is parameterised by `DEBOUNCE_CYCLES` and instantiated 9 times.
- The top level holds the FSM, the priority mask and the output registers.

## Test plan
All scenarios use DEBOUNCE_CYCLES=4.
- **Reset**: hold `rst` 3 cycles with all keys high → all outputs 0 and `up`=`down`=0 during reset and at the first cycle after.
- **Clean press**: `key_c` rises and is sampled at edge 0 and held → `c`=0 through edge 5, `c`=1 from edge 6. Release → `c`=0 six edges after the first low sample.
- **Bounce**: `key_d` sampled high 3 cycles, low 1, then held high → `d` rises exactly 6 edges after the start of the final high run; no early pulse.
- **Octave walk**: press/release `btn_up` twice → `up`=1, `down`=0 after the first press is HIGH? No: first press → MID→HIGH, `up`=1; second press → stays HIGH. Then press/release `btn_down` twice → MID (both 0), then LOW (`down`=1). A third `btn_down` press keeps LOW.
- **Simultaneous buttons**: from MID, `btn_up` and `btn_down` rise on the same edge and are held → the state stays MID and `up`=`down`=0.
- **Chord**: `key_e` and `key_a` held together.
  - With `PIANO_SINGLE_NOTE_EN`: `e`=1, `a`=0; releasing `key_e` → `a`=1 on the same edge that `e` falls.
  - Without the macro: `e`=`a`=1.
